// File: rtl/instr_packer.sv
// Packs decoded I/S/B-type fields into RV32I words and writes them sequentially to instruction memory.
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module instr_packer #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            fmt,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [31:0]           imm,
    input  logic                  rewind,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  err,
    output logic                  full
);

    typedef enum logic [1:0] {IDLE, ENC, WRITE, FULL} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t        state;
    logic [1:0]    fmt_q;
    logic [6:0]    opcode_q;
    logic [2:0]    funct3_q;
    logic [4:0]    rd_q;
    logic [4:0]    rs1_q;
    logic [4:0]    rs2_q;
    logic [31:0]   imm_q;
    logic [31:0]   word;
    logic          bad;
    logic [ADDR_WIDTH:0] count_inc;

    always_comb begin
        word = '0;
        bad  = 1'b0;
        case (fmt_q)
            2'b00:   word = {imm_q[11:0], rs1_q, funct3_q, rd_q, opcode_q};
            2'b01:   word = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], opcode_q};
            2'b10:   word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q,
                             imm_q[4:1], imm_q[11], opcode_q};
            default: bad = 1'b1;
        endcase
`ifdef IMM_RANGE_CHECK_EN
        // Sign-extension check: all bits above the field's sign bit must match it.
        case (fmt_q)
            2'b00, 2'b01: if (!((&imm_q[31:11]) || !(|imm_q[31:11]))) bad = 1'b1;
            2'b10:        if (!((&imm_q[31:12]) || !(|imm_q[31:12])) || imm_q[0]) bad = 1'b1;
            default:      ;
        endcase
`endif
    end

`ifndef IMM_RANGE_CHECK_EN
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm_q[31:13];
`endif

    assign count_inc = count + 1'b1;
    assign in_ready  = (state == IDLE) && !rewind;
    // Rewind and reset must suppress the strobe in the very cycle they are asserted.
    assign mem_we    = (state == WRITE) && !rewind && rst_n;
    assign full      = (count == DEPTH_CNT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_addr  <= ADDR_WIDTH'(BASE_ADDR);
            mem_wdata <= '0;
            count     <= '0;
            err       <= 1'b0;
            fmt_q     <= '0;
            opcode_q  <= '0;
            funct3_q  <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
        end else if (rewind) begin
            state <= IDLE;
            count <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        fmt_q    <= fmt;
                        opcode_q <= opcode;
                        funct3_q <= funct3;
                        rd_q     <= rd;
                        rs1_q    <= rs1;
                        rs2_q    <= rs2;
                        imm_q    <= imm;
                        state    <= ENC;
                    end
                end
                ENC: begin
                    if (bad) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        mem_wdata <= word;
                        mem_addr  <= ADDR_WIDTH'(BASE_ADDR) + count[ADDR_WIDTH-1:0];
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    count <= count_inc;
                    state <= (count_inc == DEPTH_CNT) ? FULL : IDLE;
                end
                FULL:    ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_packer.sv
// Randomized self-checking bench for instr_packer against an arithmetic packing model.
module tb_instr_packer;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    fmt;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [31:0]   imm;
    logic          rewind;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   count;
    logic          err;
    logic          full;

    int checks   = 0;
    int failures = 0;
    int we_events = 0;
    int m_count  = 0;
    bit m_err    = 0;

    instr_packer #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .rewind(rewind), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .count(count), .err(err), .full(full)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_we) we_events <= we_events + 1;

    function automatic logic [31:0] model_word(input logic [1:0] f, input logic [6:0] op,
                                               input logic [2:0] f3, input logic [4:0] rd_v,
                                               input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                                               input int imm_v);
        logic [31:0] u;
        logic [31:0] base;
        u = imm_v;
        base = 32'(op) | (32'(f3) << 12) | (32'(rs1_v) << 15);
        case (f)
            2'd0: return base | (32'(rd_v) << 7) | ((u & 32'hFFF) << 20);
            2'd1: return base | (32'(rs2_v) << 20) | ((u & 32'h1F) << 7) | (((u >> 5) & 32'h7F) << 25);
            2'd2: return base | (32'(rs2_v) << 20) | (((u >> 1) & 32'hF) << 8)
                              | (((u >> 11) & 32'h1) << 7) | (((u >> 5) & 32'h3F) << 25)
                              | (((u >> 12) & 32'h1) << 31);
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_reject(input logic [1:0] f, input int imm_v);
        if (f == 2'd3) return 1'b1;
`ifdef IMM_RANGE_CHECK_EN
        if (f == 2'd2) return (imm_v < -4096) || (imm_v > 4094) || ((imm_v & 1) != 0);
        return (imm_v < -2048) || (imm_v > 2047);
`else
        return 1'b0;
`endif
    endfunction

    task automatic rand_fields(output logic [1:0] f, output logic [6:0] op, output logic [2:0] f3,
                               output logic [4:0] rd_v, output logic [4:0] rs1_v,
                               output logic [4:0] rs2_v, output int imm_v, input int max_fmt);
        int edges [8] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, -4097};
        f     = 2'($urandom_range(0, max_fmt));
        op    = 7'($urandom);
        f3    = 3'($urandom);
        rd_v  = 5'($urandom);
        rs1_v = 5'($urandom);
        rs2_v = 5'($urandom);
        case ($urandom_range(0, 3))
            0:       imm_v = int'($urandom_range(0, 4095)) - 2048;
            1:       imm_v = int'($urandom_range(0, 8191)) - 4096;
            2:       imm_v = int'($urandom);
            default: imm_v = edges[$urandom_range(0, 7)];
        endcase
    endtask

    // Drives one bundle and records any write strobe over the following four cycles.
    task automatic issue(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd_v, input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                         input int imm_v, output bit accepted, output int we_seen,
                         output int we_off, output logic [AW-1:0] a, output logic [31:0] d);
        accepted = 1'b0;
        we_seen  = 0;
        we_off   = 0;
        a        = '0;
        d        = '0;
        for (int i = 0; i < 10; i++) begin
            if (in_ready) begin
                accepted = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!accepted) return;
        fmt = f; opcode = op; funct3 = f3; rd = rd_v; rs1 = rs1_v; rs2 = rs2_v; imm = imm_v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (mem_we) begin
                we_seen++;
                if (we_off == 0) begin
                    we_off = k;
                    a = mem_addr;
                    d = mem_wdata;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_rewind();
        rewind = 1'b1;
        @(posedge clk); #1;
        rewind = 1'b0;
        m_count = 0;
        m_err = 0;
    endtask

    // Issues a bundle and compares every observable against the model, then advances it.
    task automatic run_one(input string tag, input logic [1:0] f, input logic [6:0] op,
                           input logic [2:0] f3, input logic [4:0] rd_v, input logic [4:0] rs1_v,
                           input logic [4:0] rs2_v, input int imm_v);
        bit accepted;
        int we_seen, we_off;
        logic [AW-1:0] a;
        logic [31:0] d;
        bit rej;
        rej = model_reject(f, imm_v);
        issue(f, op, f3, rd_v, rs1_v, rs2_v, imm_v, accepted, we_seen, we_off, a, d);
        checks++;
        if (accepted !== 1'b1) begin
            failures++;
            $display("FAIL %s accept: got=%0d want=1", tag, accepted);
        end
        if (rej) begin
            m_err = 1;
            checks++;
            if (we_seen != 0) begin
                failures++;
                $display("FAIL %s reject_no_write: got=%0d writes want=0", tag, we_seen);
            end
        end else begin
            checks++;
            if (we_seen != 1 || we_off != 2) begin
                failures++;
                $display("FAIL %s write_timing: got=%0d writes at offset %0d want=1 at 2", tag, we_seen, we_off);
            end
            checks++;
            if (a !== AW'(m_count % DEPTH)) begin
                failures++;
                $display("FAIL %s addr: got=%0d want=%0d", tag, a, m_count % DEPTH);
            end
            checks++;
            if (d !== model_word(f, op, f3, rd_v, rs1_v, rs2_v, imm_v)) begin
                failures++;
                $display("FAIL %s wdata: got=%08h want=%08h", tag, d, model_word(f, op, f3, rd_v, rs1_v, rs2_v, imm_v));
            end
            m_count++;
        end
        checks++;
        if (count !== (AW+1)'(m_count)) begin
            failures++;
            $display("FAIL %s count: got=%0d want=%0d", tag, count, m_count);
        end
        checks++;
        if (err !== m_err) begin
            failures++;
            $display("FAIL %s err: got=%0d want=%0d", tag, err, m_err);
        end
        checks++;
        if (full !== (m_count == DEPTH)) begin
            failures++;
            $display("FAIL %s full: got=%0d want=%0d", tag, full, m_count == DEPTH);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset in_ready: got=%0d want=1", in_ready); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset mem_we: got=%0d want=0", mem_we); end
        checks++; if (mem_addr !== '0) begin failures++; $display("FAIL reset mem_addr: got=%0d want=0", mem_addr); end
        checks++; if (mem_wdata !== '0) begin failures++; $display("FAIL reset mem_wdata: got=%08h want=0", mem_wdata); end
        checks++; if (count !== '0) begin failures++; $display("FAIL reset count: got=%0d want=0", count); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset err: got=%0d want=0", err); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset full: got=%0d want=0", full); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        m_count = 0;
        m_err = 0;
    endtask

    task automatic test_i_type();
        run_one("i_type", 2'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 5);
        checks++;
        if (mem_wdata !== 32'h00500093) begin
            failures++;
            $display("FAIL i_type golden: got=%08h want=00500093", mem_wdata);
        end
    endtask

    task automatic test_s_b();
        do_rewind();
        run_one("s_type", 2'd1, 7'h23, 3'd2, 5'd0, 5'd3, 5'd2, -4);
        checks++;
        if (mem_wdata !== 32'hFE21AE23 || mem_addr !== AW'(0)) begin
            failures++;
            $display("FAIL s_golden: got=%08h@%0d want=FE21AE23@0", mem_wdata, mem_addr);
        end
        run_one("b_type", 2'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, -8);
        checks++;
        if (mem_wdata !== 32'hFE208CE3 || mem_addr !== AW'(1)) begin
            failures++;
            $display("FAIL b_golden: got=%08h@%0d want=FE208CE3@1", mem_wdata, mem_addr);
        end
    endtask

    task automatic test_range();
        do_rewind();
        run_one("range_i2048", 2'd0, 7'h13, 3'd0, 5'd4, 5'd5, 5'd0, 2048);
        run_one("range_b3", 2'd2, 7'h63, 3'd1, 5'd0, 5'd6, 5'd7, 3);
        run_one("range_fmt3", 2'd3, 7'h13, 3'd0, 5'd1, 5'd1, 5'd1, 1);
        run_one("range_after", 2'd0, 7'h13, 3'd0, 5'd2, 5'd3, 5'd0, 7);
    endtask

    task automatic test_random();
        logic [1:0] f; logic [6:0] op; logic [2:0] f3; logic [4:0] rd_v, rs1_v, rs2_v; int imm_v;
        do_rewind();
        for (int n = 0; n < 40; n++) begin
            if (m_count == DEPTH) do_rewind();
            rand_fields(f, op, f3, rd_v, rs1_v, rs2_v, imm_v, 3);
            run_one("random", f, op, f3, rd_v, rs1_v, rs2_v, imm_v);
        end
    endtask

    task automatic test_full();
        logic [1:0] f; logic [6:0] op; logic [2:0] f3; logic [4:0] rd_v, rs1_v, rs2_v; int imm_v;
        int e0;
        do_rewind();
        for (int n = 0; n < int'(DEPTH); n++) begin
            rand_fields(f, op, f3, rd_v, rs1_v, rs2_v, imm_v, 2);
            imm_v = imm_v & 32'h7FE;
            run_one("fill", f, op, f3, rd_v, rs1_v, rs2_v, imm_v);
        end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full in_ready: got=%0d want=0", in_ready); end
        e0 = we_events;
        rand_fields(f, op, f3, rd_v, rs1_v, rs2_v, imm_v, 2);
        fmt = f; opcode = op; funct3 = f3; rd = rd_v; rs1 = rs1_v; rs2 = rs2_v; imm = imm_v;
        in_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++; if (we_events != e0) begin failures++; $display("FAIL full_ignore writes: got=%0d want=%0d", we_events, e0); end
        checks++; if (count !== (AW+1)'(DEPTH)) begin failures++; $display("FAIL full_ignore count: got=%0d want=%0d", count, DEPTH); end
        do_rewind();
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL rewind full: got=%0d want=0", full); end
        checks++; if (count !== '0) begin failures++; $display("FAIL rewind count: got=%0d want=0", count); end
        run_one("after_rewind", 2'd0, 7'h13, 3'd3, 5'd9, 5'd8, 5'd0, -1);
    endtask

    task automatic test_abort();
        int e0;
        do_rewind();
        run_one("abort_err", 2'd3, 7'h03, 3'd0, 5'd1, 5'd1, 5'd1, 0);
        rewind = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rewind_idle in_ready: got=%0d want=0", in_ready); end
        @(posedge clk); #1;
        rewind = 1'b0;
        m_count = 0; m_err = 0;
        run_one("abort_err2", 2'd3, 7'h03, 3'd0, 5'd1, 5'd1, 5'd1, 0);
        e0 = we_events;
        fmt = 2'd0; opcode = 7'h13; funct3 = 3'd0; rd = 5'd1; rs1 = 5'd2; rs2 = 5'd0; imm = 32'd9;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rewind = 1'b1;
        @(posedge clk); #1;
        rewind = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        m_count = 0; m_err = 0;
        checks++; if (we_events != e0) begin failures++; $display("FAIL abort_enc writes: got=%0d want=%0d", we_events, e0); end
        checks++; if (count !== '0) begin failures++; $display("FAIL abort_enc count: got=%0d want=0", count); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL abort_enc err: got=%0d want=0", err); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL abort_enc in_ready: got=%0d want=1", in_ready); end
        run_one("abort_err3", 2'd3, 7'h03, 3'd0, 5'd1, 5'd1, 5'd1, 0);
        e0 = we_events;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL abort_rst mem_we: got=%0d want=0", mem_we); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        m_count = 0; m_err = 0;
        checks++; if (we_events != e0) begin failures++; $display("FAIL abort_rst writes: got=%0d want=%0d", we_events, e0); end
        checks++; if (count !== '0) begin failures++; $display("FAIL abort_rst count: got=%0d want=0", count); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL abort_rst err: got=%0d want=0", err); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL abort_rst in_ready: got=%0d want=1", in_ready); end
        checks++; if (mem_wdata !== '0 || mem_addr !== '0) begin failures++; $display("FAIL abort_rst outputs: got=%08h@%0d want=0@0", mem_wdata, mem_addr); end
        @(posedge clk); #1;
        run_one("after_reset", 2'd1, 7'h23, 3'd2, 5'd0, 5'd3, 5'd2, -4);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; rewind = 1'b0;
        fmt = '0; opcode = '0; funct3 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        @(posedge clk); #1;
        test_reset();
        test_i_type();
        test_s_b();
        test_range();
        test_random();
        test_full();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_packer.md
# instr_packer

Encoder counterpart to the core's immediate decoder. Accepts decoded instruction fields (format, opcode, funct3, register indices, signed immediate) over a valid/ready handshake and packs them into 32-bit RV32I I/S/B-type machine words. Each word is written sequentially into instruction memory through a single write port. It serves as the program loader for testbenches and boot, and its output round-trips through the decoder.

## Interface
- ADDR_WIDTH, 8, word-address width of the instruction memory write port; DEPTH = 2**ADDR_WIDTH words
- BASE_ADDR, 0, first word address written after reset/rewind
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  block can accept a bundle this cycle
- fmt  in  2  00 I-type, 01 S-type, 10 B-type, 11 reserved
- opcode  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- rd  in  5  destination register (I only)
- rs1  in  5  source 1 (all formats)
- rs2  in  5  source 2 (S, B only)
- imm  in  32  signed immediate, two's complement; B-type is a byte offset
- rewind  in  1  restart write pointer at BASE_ADDR, clear err
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  ADDR_WIDTH  word address, (BASE_ADDR + count) mod DEPTH
- mem_wdata  out  32  packed instruction
- count  out  ADDR_WIDTH+1  words written since reset/rewind
- err  out  1  sticky: a bundle was rejected
- full  out  1  count == DEPTH

## Operation
- FSM states: IDLE, ENC, WRITE, FULL.
- IDLE: in_ready=1. If in_valid, fields are latched and the FSM moves to ENC.
- ENC: the word is packed and checked, then registered into mem_wdata.
  - On error: err<=1, no write, return to IDLE.
  - Otherwise: go to WRITE.
- WRITE: mem_we=1 for exactly this cycle. Then count<=count+1. Go to FULL if the new count == DEPTH, else IDLE.
- FULL: in_ready=0 and all in_valid is ignored. Only rewind or reset leaves this state.
- Packing rules:
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
- Fields unused by the selected format are ignored.
- Errors: fmt==11 always rejects. Range rejections are described under Configuration.
- rewind:
  - Sampled every cycle and has priority over the handshake.
  - Sets count<=0 and err<=0, and moves the FSM to IDLE.
  - If asserted in ENC or WRITE, the in-flight bundle is dropped and mem_we stays 0 that cycle.
  - in_ready=0 in any cycle rewind=1.

## Timing
- Reset values: state IDLE, in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, err=0, full=0.
- Accept at edge N (in_valid & in_ready). Then ENC is cycle N+1 and mem_we=1 is cycle N+2, with addr/wdata valid the same cycle.
- Throughput: one bundle per 3 cycles. in_ready is 0 in ENC, WRITE and FULL.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Reset asserted mid-operation aborts with no write, and all outputs return to reset values on the next edge.

## Configuration
- IMM_RANGE_CHECK_EN defined:
  - I/S imm must lie in [-2048, 2047].
  - B imm must lie in [-4096, 4094] and be even (imm[0]==0).
  - Violations set err and are not written.
- Undefined: the immediate is silently truncated to the format's bits (B drops imm[0]). Only fmt==11 sets err.

## Test plan
- I-type: fmt=00, opcode=0x13, funct3=0, rd=1, rs1=0, imm=5 -> two cycles after accept, mem_we=1, addr=0, wdata=0x00500093, count=1.
- S/B: S-type with opcode=0x23, funct3=2, rs1=3, rs2=2, imm=-4 -> 0xFE21AE23 at addr 0. Then B-type with opcode=0x63, funct3=0, rs1=1, rs2=2, imm=-8 -> 0xFE208CE3 at addr 1.
- Range (macro on): I imm=2048, then B imm=3 -> err=1, no mem_we, count unchanged. A following valid bundle is written at the same addr and err stays 1.
- Full: ADDR_WIDTH=2, four valid bundles -> addrs 0..3, full=1, in_ready=0, a 5th bundle is ignored. Then rewind -> full=0, count=0, and the next word goes to addr 0.
- Abort: rewind asserted in ENC, and separately rst_n=0 in WRITE -> mem_we never pulses, count=0, err=0, in_ready=1 after release.
